// File: rtl/serial_rx.sv
// serial_rx: oversampled asynchronous serial receiver (8N1, LSB first).
// A start bit is confirmed at its midpoint, then each data bit and the stop
// bit are sampled one full bit period later. Completed bytes go to a
// single-entry output slot with a valid/ready handshake. The slot can report
// a framing error or an overrun.
module serial_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_sync1, r_sync2;
  logic          w_rx_s;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shreg, w_shreg_nxt;
  logic [7:0]    r_dout, w_dout_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_ferr, w_ferr_nxt;
  logic          r_ovr, w_ovr_nxt;
  logic          w_slot_free;

  assign w_rx_s      = r_sync2;
  // The slot is free if it is empty, or if its byte is consumed this cycle.
  assign w_slot_free = !r_valid || dout_ready;

  // Two-flop synchronizer for the asynchronous line. It resets to idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receiver state, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
      r_ovr   <= w_ovr_nxt;
    end
  end

  // Next-state and output logic. The handshake consumes the slot
  // independently of the frame being received.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_dout_nxt  = r_dout;
    w_valid_nxt = r_valid && !dout_ready;
    w_ferr_nxt  = 1'b0;
    w_ovr_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        if (r_cnt == HALF) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_shreg_nxt = {w_rx_s, r_shreg[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (!w_rx_s) begin
            w_ferr_nxt = 1'b1;
          end else if (w_slot_free) begin
            w_dout_nxt  = r_shreg;
            w_valid_nxt = 1'b1;
          end else begin
            w_ovr_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_serial_rx.sv
// Testbench for serial_rx: directed frames plus randomized traffic, checked
// every cycle against a sample-instant model of the receiver.
module tb_serial_rx;
  localparam int N = 16;
  localparam int H = N / 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       dout_ready = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_err;
  logic       overrun;

  serial_rx #(.CLKS_PER_BIT(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int fe_seen = 0;
  int ov_seen = 0;

  // Input values as seen by the DUT at each rising edge.
  logic cap_rx = 1'b1, cap_rdy = 1'b0, cap_rst = 1'b0;
  initial forever begin
    @(posedge clk);
    cap_rx  = rx;
    cap_rdy = dout_ready;
    cap_rst = rst_n;
  end

  // Model state: the line value at edge j is rx from edge j-2 (synchronizer).
  // A frame detected at edge ts has its start-bit midpoint check at ts+H,
  // data bit i sampled at ts+H+N*(i+1), and the stop bit sampled at ts+H+9N.
  logic [7:0] bits = '0, exp_dout = '0;
  logic       exp_valid = 1'b0, exp_fe = 1'b0, exp_ov = 1'b0;

  initial begin : monitor
    logic h1, h2, rs, nv, busy;
    int   ts, d, cyc;
    h1 = 1'b1; h2 = 1'b1; busy = 1'b0; ts = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!cap_rst || !rst_n) begin
        h1 = 1'b1; h2 = 1'b1; busy = 1'b0;
        bits = '0; exp_dout = '0; exp_valid = 1'b0; exp_fe = 1'b0; exp_ov = 1'b0;
      end else begin
        rs = h2; h2 = h1; h1 = cap_rx;
        exp_fe = 1'b0; exp_ov = 1'b0;
        nv = exp_valid && !cap_rdy;
        if (busy) begin
          d = cyc - ts;
          if (d == H) begin
            if (rs) busy = 1'b0;
          end else if (d < H + 9 * N) begin
            if (d > H && (d - H) % N == 0) bits[(d - H) / N - 1] = rs;
          end else begin
            busy = 1'b0;
            if (!rs) exp_fe = 1'b1;
            else if (!exp_valid || cap_rdy) begin
              exp_dout = bits;
              nv = 1'b1;
            end else exp_ov = 1'b1;
          end
        end else if (!rs) begin
          busy = 1'b1;
          ts = cyc;
        end
        exp_valid = nv;
      end
      n_cmp++;
      if ({dout, dout_valid, frame_err, overrun} !== {exp_dout, exp_valid, exp_fe, exp_ov}) begin
        n_bad++;
        $display("FAIL cycle %0d outputs: dout=%h valid=%b ferr=%b ovr=%b, required dout=%h valid=%b ferr=%b ovr=%b",
                 cyc, dout, dout_valid, frame_err, overrun, exp_dout, exp_valid, exp_fe, exp_ov);
      end
      if (frame_err === 1'b1) fe_seen++;
      if (overrun === 1'b1) ov_seen++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame; optionally raise dout_ready for exactly the edge at which
  // the stop bit is sampled (start edge + 9N + H + 2).
  task automatic send(input logic [7:0] b, input logic stp, input bit rdy_end);
    rx = 1'b0;
    step(N);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      step(N);
    end
    rx = stp;
    if (rdy_end) begin
      step(H + 2);
      dout_ready = 1'b1;
      step(1);
      dout_ready = 1'b0;
      step(N - H - 3);
    end else begin
      step(N);
    end
    rx = 1'b1;
  endtask

  task automatic consume();
    dout_ready = 1'b1;
    step(1);
    dout_ready = 1'b0;
  endtask

  int fe0, ov0;
  bit rnd_on;

  initial begin
    // Reset state
    step(4);
    chk("reset dout", 32'(dout), 32'h00);
    chk("reset valid", 32'(dout_valid), 32'h0);
    chk("reset ferr", 32'(frame_err), 32'h0);
    chk("reset ovr", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    step(20);

    // 0xA5, held while not consumed
    send(8'hA5, 1'b1, 1'b0);
    chk("A5 dout", 32'(dout), 32'hA5);
    chk("A5 model", 32'(exp_dout), 32'hA5);
    chk("A5 valid", 32'(dout_valid), 32'h1);
    step(50);
    chk("A5 held", 32'(dout_valid), 32'h1);
    chk("A5 no errors", 32'(fe_seen + ov_seen), 32'h0);
    consume();
    chk("A5 consumed", 32'(dout_valid), 32'h0);

    // Short glitch is rejected
    rx = 1'b0;
    step(4);
    rx = 1'b1;
    step(40);
    chk("glitch valid", 32'(dout_valid), 32'h0);
    chk("glitch errors", 32'(fe_seen + ov_seen), 32'h0);

    // Bad stop bit
    fe0 = fe_seen;
    send(8'h3C, 1'b0, 1'b0);
    step(3 * N);
    chk("3C ferr pulses", 32'(fe_seen - fe0), 32'h1);
    chk("3C valid", 32'(dout_valid), 32'h0);
    chk("3C dout kept", 32'(dout), 32'hA5);

    // Overrun
    ov0 = ov_seen;
    send(8'h11, 1'b1, 1'b0);
    chk("11 dout", 32'(dout), 32'h11);
    send(8'h22, 1'b1, 1'b0);
    chk("22 dropped", 32'(dout), 32'h11);
    chk("22 model", 32'(exp_dout), 32'h11);
    chk("22 ovr pulses", 32'(ov_seen - ov0), 32'h1);
    chk("22 valid", 32'(dout_valid), 32'h1);
    consume();
    chk("11 consumed", 32'(dout_valid), 32'h0);

    // Same-cycle accept and reload
    ov0 = ov_seen;
    send(8'h55, 1'b1, 1'b0);
    send(8'h66, 1'b1, 1'b1);
    chk("66 dout", 32'(dout), 32'h66);
    chk("66 valid", 32'(dout_valid), 32'h1);
    chk("66 no ovr", 32'(ov_seen - ov0), 32'h0);
    consume();

    // Reset during data bit 4 of 0xFF
    rx = 1'b0;
    step(N);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b1;
      step(N);
    end
    step(H);
    rst_n = 1'b0;
    step(3);
    chk("midreset dout", 32'(dout), 32'h00);
    chk("midreset valid", 32'(dout_valid), 32'h0);
    chk("midreset ferr", 32'(frame_err), 32'h0);
    chk("midreset ovr", 32'(overrun), 32'h0);
    rst_n = 1'b1;
    step(5 * N);
    chk("post reset idle", 32'(dout_valid), 32'h0);
    send(8'h0F, 1'b1, 1'b0);
    chk("0F dout", 32'(dout), 32'h0F);
    consume();
    step(10);

    // Randomized traffic with a random consumer
    rnd_on = 1'b1;
    fork
      begin
        int r, g;
        for (int f = 0; f < 150; f++) begin
          r = int'($urandom_range(0, 9));
          if (r == 0) begin
            rx = 1'b0;
            step(int'($urandom_range(1, H - 2)));
            rx = 1'b1;
            step(N);
          end else begin
            send(8'($urandom_range(0, 255)), (r == 1) ? 1'b0 : 1'b1, 1'b0);
          end
          g = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20));
          step(g);
        end
        step(4 * N);
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          dout_ready = ($urandom_range(0, 3) == 0);
          step(1);
        end
        dout_ready = 1'b0;
      end
    join
    step(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
